// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits, LSB first, optional even/odd parity, one stop bit.
// Single-entry handshake on tx_valid/tx_ready; the line idles high.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       tx_busy
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        data_q, data_d;
    logic              serial_d;
    logic              bit_end;

    // The line value is computed from the next state so serial_out can be a
    // plain register and still change on the same edge as the state.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        bit_d    = bit_q;
        data_d   = data_q;
        bit_end  = (baud_q == BAUD_LAST);
        baud_d   = bit_end ? '0 : baud_q + 1'b1;
        serial_d = 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = data_d[bit_d];
            PARITY:  serial_d = (^data_d) ^ (PARITY_ODD != 0);
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the values from before this edge, independent of statement order.
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            // NOTE: the data holding register is cleared on reset as well, so
            // no stale byte from an aborted frame is ever visible internally.
            data_q     <= '0;
            serial_out <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            serial_out <= serial_d;
        end
    end

    // Reset gates both flags so the source sees neither ready nor busy while held.
    assign tx_ready = (state_q == IDLE) && !reset;
    assign tx_busy  = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three instances (no parity, even, odd) at
// CLKS_PER_BIT=4, checked cycle by cycle against a frame-level line model.
module tb_uart_tx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic [2:0] valid = 3'b000;
    logic [2:0] ready;
    logic [2:0] ser;
    logic [2:0] busy;

    int total = 0;
    int bad   = 0;

    logic line_q[$];
    logic busy_q[$];
    logic exp_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .serial_out(ser[0]), .tx_busy(busy[0]));
    uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .serial_out(ser[1]), .tx_busy(busy[1]));
    uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .serial_out(ser[2]), .tx_busy(busy[2]));

    // Reference model: list the frame's bits, then stretch each to N cycles.
    task automatic build_exp(input logic [7:0] b, input int par_en, input int par_odd);
        logic bits[$];
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(((b >> k) & 8'd1) != 0);
        if (par_en != 0) bits.push_back((($countones(b) % 2) != 0) ^ (par_odd != 0));
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (N) exp_q.push_back(bits[i]);
    endtask

    function automatic int frame_len(input int which);
        return (which == 0) ? 10 * N : 11 * N;
    endfunction

    // Present a byte and hold it until the DUT is ready; ok reports acceptance.
    task automatic launch(input int which, input logic [7:0] b, output bit ok);
        int n = 0;
        @(negedge clk);
        tx_data = b;
        valid[which] = 1'b1;
        while (!ready[which] && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = ready[which];
        @(posedge clk);
        #1 valid[which] = 1'b0;
    endtask

    task automatic capture(input int which, input int n);
        line_q.delete();
        busy_q.delete();
        repeat (n) begin
            @(negedge clk);
            line_q.push_back(ser[which]);
            busy_q.push_back(busy[which]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ser !== 3'b111 || ready !== 3'b000 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset_state: serial=%b ready=%b busy=%b, required 111/000/000", ser, ready, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 3'b111 || ser !== 3'b111 || busy !== 3'b000) begin
            bad++;
            $display("FAIL reset_release: ready=%b serial=%b busy=%b, required 111/111/000", ready, ser, busy);
        end
    endtask

    task automatic test_single(input string name, input int which, input logic [7:0] b);
        bit ok;
        int pe = (which != 0) ? 1 : 0;
        int po = (which == 2) ? 1 : 0;
        exp_q.delete();
        build_exp(b, pe, po);
        launch(which, b, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_accept: tx_ready never rose, required 1", name);
        end
        capture(which, frame_len(which));
        for (int c = 0; c < frame_len(which); c++) begin
            total++;
            if (line_q[c] !== exp_q[c] || busy_q[c] !== 1'b1) begin
                bad++;
                $display("FAIL %s cycle %0d: serial_out=%b tx_busy=%b, required %b and 1",
                         name, c, line_q[c], busy_q[c], exp_q[c]);
            end
        end
        @(negedge clk);
        total++;
        if (ser[which] !== 1'b1 || busy[which] !== 1'b0 || ready[which] !== 1'b1) begin
            bad++;
            $display("FAIL %s_idle: serial_out=%b tx_busy=%b tx_ready=%b, required 1/0/1",
                     name, ser[which], busy[which], ready[which]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            int          which = int'($urandom_range(0, 2));
            logic [7:0]  b     = 8'($urandom);
            test_single($sformatf("random%0d_dut%0d_%02h", i, which, b), which, b);
        end
    endtask

    task automatic test_back_to_back();
        int   accepts = 0;
        int   acc_at[$];
        int   cyc = 0;
        bit   started = 0;
        logic acc_now;
        exp_q.delete();
        build_exp(8'h01, 0, 0);
        exp_q.push_back(1'b1);
        build_exp(8'h80, 0, 0);
        line_q.delete();
        busy_q.delete();
        @(negedge clk);
        tx_data = 8'h01;
        valid[0] = 1'b1;
        while (line_q.size() < exp_q.size() && cyc < 300) begin
            if (cyc != 0) @(negedge clk);
            if (started) line_q.push_back(ser[0]);
            acc_now = ready[0] & valid[0];
            @(posedge clk);
            #1;
            if (acc_now) begin
                accepts++;
                acc_at.push_back(line_q.size());
                started = 1;
                if (accepts == 1) tx_data = 8'h80;
                else valid[0] = 1'b0;
            end
            cyc++;
        end
        valid[0] = 1'b0;
        total++;
        if (accepts != 2) begin
            bad++;
            $display("FAIL b2b_accept_count: accepted %0d bytes, required 2", accepts);
        end
        total++;
        if (acc_at.size() < 2 || acc_at[1] != 10 * N + 1) begin
            bad++;
            $display("FAIL b2b_gap: second acceptance after %0d line cycles, required %0d",
                     (acc_at.size() < 2) ? -1 : acc_at[1], 10 * N + 1);
        end
        for (int c = 0; c < exp_q.size(); c++) begin
            total++;
            if (c >= line_q.size() || line_q[c] !== exp_q[c]) begin
                bad++;
                $display("FAIL b2b cycle %0d: serial_out=%b, required %b",
                         c, (c < line_q.size()) ? line_q[c] : 1'bx, exp_q[c]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_data_change();
        bit ok;
        exp_q.delete();
        build_exp(8'h0F, 0, 0);
        launch(0, 8'h0F, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_accept: tx_ready never rose, required 1");
        end
        fork
            capture(0, 10 * N);
            begin
                @(negedge clk);
                tx_data = 8'hF0;
            end
        join
        for (int c = 0; c < 10 * N; c++) begin
            total++;
            if (line_q[c] !== exp_q[c]) begin
                bad++;
                $display("FAIL hold cycle %0d: serial_out=%b, required %b", c, line_q[c], exp_q[c]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        exp_q.delete();
        build_exp(8'h96, 0, 0);
        launch(0, 8'h96, ok);
        capture(0, 4 * N + 2);
        total++;
        if (!ok || line_q[4 * N + 1] !== exp_q[4 * N + 1]) begin
            bad++;
            $display("FAIL abort_pre: accepted=%0b bit3 serial_out=%b, required 1 and %b",
                     ok, line_q[4 * N + 1], exp_q[4 * N + 1]);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset: serial_out=%b tx_busy=%b tx_ready=%b, required 1/0/0",
                     ser[0], busy[0], ready[0]);
        end
        reset = 1'b0;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            total++;
            if (ser[0] !== 1'b1 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
                bad++;
                $display("FAIL abort_no_resume cycle %0d: serial_out=%b tx_busy=%b tx_ready=%b, required 1/0/1",
                         c, ser[0], busy[0], ready[0]);
            end
        end
        test_single("after_abort_3c", 0, 8'h3C);
    endtask

    task automatic test_reset_with_valid();
        @(negedge clk);
        reset = 1'b1;
        tx_data = 8'h00;
        valid = 3'b111;
        @(negedge clk);
        reset = 1'b0;
        valid = 3'b000;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            total++;
            if (ser !== 3'b111 || busy !== 3'b000) begin
                bad++;
                $display("FAIL reset_priority cycle %0d: serial=%b busy=%b, required 111/000", c, ser, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single("send_55", 0, 8'h55);
        test_single("even_a5", 1, 8'hA5);
        test_single("odd_a5", 2, 8'hA5);
        test_random();
        test_back_to_back();
        test_data_change();
        test_reset_mid_frame();
        test_reset_with_valid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required the bench to finish first");
        $fatal(1, "watchdog");
    end

endmodule
